sram_arbiter: RTL and testbench

- Shares one asynchronous 512K×8 SRAM bank (mb0 or mb1) between two requesters.
- Port 0 is the video fetcher; port 1 is the CPU/bus side.
- Sequences SRAM strobes with a fixed number of wait states and returns read data with a one-cycle acknowledge.
- The top level instantiates one arbiter per bank and wires the SRAM-side outputs to the `mbN_*` pins, with `sram_dq_oe` driving the tristate on `mbN_data`.

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_arb_pick.sv | 42 ++++
 rtl/sram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM arbiter.
// Holds the FSM state type, default widths and the wait counter width.
package sram_arb_pkg;

  localparam int ADDR_W_DEF      = 19;
  localparam int DATA_W_DEF      = 8;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int WAIT_CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: winner selection for the two SRAM requesters.
// Ports: req0/req1 in, win1 out (1 = port 1 wins); with the macro
// SRAM_ARB_ROUND_ROBIN_EN also clock/reset/grant for the pointer register.
module sram_arb_pick
  import sram_arb_pkg::*;
(
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  input  logic clock,
  input  logic reset,
  input  logic grant,
`endif
  input  logic req0,
  input  logic req1,
  output logic win1
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // last1 = port 1 was granted last; reset value hands the
  // first contention to port 0.
  logic last1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last1 <= 1'b1;
    end else if (grant) begin
      last1 <= win1;
    end
  end

  always_comb begin
    win1 = req1;
    if (req0 && req1) begin
      win1 = ~last1;
    end
  end
`else
  always_comb begin
    win1 = req1 & ~req0;
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM bank between the video
// fetcher (port 0) and the CPU (port 1) with registered strobes,
// WAIT_CYCLES wait states and a one-cycle ack. Optional macro:
// SRAM_ARB_ROUND_ROBIN_EN (round-robin on contention, else port 0 wins).
// Ports: clock, reset; req/we/addr/wdata/ack per port; shared rdata;
// sram_addr, sram_dout, sram_din, sram_ce_n/oe_n/we_n, sram_dq_oe.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_dq_oe
);

  state_t    state_q;
  state_t    state_d;
  wait_cnt_t cnt_q;
  wait_cnt_t cnt_d;
  logic      sel1_q;
  logic      sel1_d;
  logic      wr_q;
  logic      wr_d;

  logic              win1;
  logic              req_any;
  logic              wr_new;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dout_d;
  logic [DATA_W-1:0] rdata_d;
  logic              ack0_d;
  logic              ack1_d;
  logic              ce_n_d;
  logic              oe_n_d;
  logic              we_n_d;
  logic              dq_oe_d;

  assign req_any = req0 | req1;
  assign wr_new  = win1 ? we1 : we0;

  sram_arb_pick u_pick (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    .clock (clock),
    .reset (reset),
    .grant ((state_q == IDLE) && req_any),
`endif
    .req0  (req0),
    .req1  (req1),
    .win1  (win1)
  );

  // Next values for every register; all outputs are flops, so the
  // strobes for a state are set up on the edge that enters it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel1_d  = sel1_q;
    wr_d    = wr_q;
    addr_d  = sram_addr;
    dout_d  = sram_dout;
    rdata_d = rdata;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    ce_n_d  = sram_ce_n;
    oe_n_d  = sram_oe_n;
    we_n_d  = sram_we_n;
    dq_oe_d = sram_dq_oe;
    unique case (state_q)
      IDLE: begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        if (req_any) begin
          sel1_d  = win1;
          wr_d    = wr_new;
          addr_d  = win1 ? addr1 : addr0;
          dout_d  = win1 ? wdata1 : wdata0;
          cnt_d   = WAIT_CNT_W'(WAIT_CYCLES - 1);
          state_d = ACCESS;
          ce_n_d  = 1'b0;
          oe_n_d  = wr_new;
          we_n_d  = ~wr_new;
          dq_oe_d = wr_new;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          ack0_d  = ~sel1_q;
          ack1_d  = sel1_q;
          if (!wr_q) begin
            rdata_d = sram_din;
          end
        end else begin
          cnt_d = cnt_q - wait_cnt_t'(1);
        end
      end
      DONE: begin
        // Write data was held through DONE; release it now.
        dq_oe_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel1_q     <= 1'b0;
      wr_q       <= 1'b0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      rdata      <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel1_q     <= sel1_d;
      wr_q       <= wr_d;
      sram_addr  <= addr_d;
      sram_dout  <= dout_d;
      rdata      <= rdata_d;
      ack0       <= ack0_d;
      ack1       <= ack1_d;
      sram_ce_n  <= ce_n_d;
      sram_oe_n  <= oe_n_d;
      sram_we_n  <= we_n_d;
      sram_dq_oe <= dq_oe_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and random checks of sram_arbiter against
// a transaction-timing reference model and a behavioural SRAM.
module tb_sram_arbiter;

  localparam int W = 2;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [18:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1;
  logic [7:0]  rdata;
  logic [18:0] sram_addr;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din = 8'h00;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;

  always #5 clock = ~clock;

  sram_arbiter #(
    .ADDR_W      (19),
    .DATA_W      (8),
    .WAIT_CYCLES (W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .ack0       (ack0),
    .ack1       (ack1),
    .rdata      (rdata),
    .sram_addr  (sram_addr),
    .sram_dout  (sram_dout),
    .sram_din   (sram_din),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_dq_oe (sram_dq_oe)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Memories: device (behind the pins) and reference (model view).
  logic [7:0] dev_mem [int];
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] init_val(input int a);
    return 8'(a ^ (a >> 8) ^ 32'h5A);
  endfunction

  function automatic logic [7:0] dev_rd(input int a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  always @(negedge clock) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe)
      dev_mem[int'(sram_addr)] = sram_dout;
    sram_din = (!sram_ce_n && !sram_oe_n) ? dev_rd(int'(sram_addr)) : 8'h00;
  end

  // Reference model: one access occupies sample edge s, strobes for
  // periods s..s+W-1, ack in period s+W, next sample at s+W+2.
  int          edge_n = 0;
  int          free_edge = 0;
  bit          act = 0;
  int          s_edge = 0;
  bit          m_port, m_we;
  logic [18:0] m_addr;
  logic [7:0]  m_wd;
  bit          last1 = 1;
  logic [7:0]  exp_rdata = 8'h00;

  bit auto_en = 0;
  bit keep0 = 0;
  bit keep1 = 0;

  int ack_edges[$];
  bit ack_ports[$];
  int grant_edges[$];
  bit grant_ports[$];
  int n_dq, n_wel, n_oel;

  task automatic clear_logs();
    ack_edges.delete();
    ack_ports.delete();
    grant_edges.delete();
    grant_ports.delete();
    n_dq = 0;
    n_wel = 0;
    n_oel = 0;
  endtask

  task automatic model_edge();
    bit p;
    edge_n++;
    if (act && edge_n > s_edge + W) act = 0;
    if (!act && edge_n >= free_edge && (req0 || req1)) begin
      if (req0 && req1) p = RR ? !last1 : 1'b0;
      else p = req1;
      last1 = p;
      act = 1;
      s_edge = edge_n;
      m_port = p;
      m_we = p ? we1 : we0;
      m_addr = p ? addr1 : addr0;
      m_wd = p ? wdata1 : wdata0;
      free_edge = edge_n + W + 2;
      grant_edges.push_back(edge_n);
      grant_ports.push_back(p);
    end
  endtask

  task automatic check_cycle();
    bit acc, dn;
    acc = act && edge_n >= s_edge && edge_n < s_edge + W;
    dn = act && edge_n == s_edge + W;
    if (dn && !m_we) exp_rdata = ref_rd(int'(m_addr));
    if (dn && m_we) ref_mem[int'(m_addr)] = m_wd;
    chk("ack0", ack0, dn && !m_port);
    chk("ack1", ack1, dn && m_port);
    chk("ce_n", sram_ce_n, !acc);
    chk("oe_n", sram_oe_n, !(acc && !m_we));
    chk("we_n", sram_we_n, !(acc && m_we));
    chk("dq_oe", sram_dq_oe, (acc || dn) && m_we);
    if (acc) chk("sram_addr", sram_addr, m_addr);
    if (acc && m_we) chk("sram_dout", sram_dout, m_wd);
    chk("rdata", rdata, exp_rdata);
    if (ack0 || ack1) begin
      ack_edges.push_back(edge_n);
      ack_ports.push_back(ack1);
    end
    if (sram_dq_oe) n_dq++;
    if (!sram_we_n) n_wel++;
    if (!sram_oe_n) n_oel++;
  endtask

  task automatic rand_req(output logic w, output logic [18:0] a,
                          output logic [7:0] d);
    w = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) a = 19'($urandom);
    else a = 19'($urandom_range(0, 31));
    d = 8'($urandom);
  endtask

  task automatic drive();
    if (ack0 && req0) begin
      if (auto_en) begin
        if ($urandom_range(0, 1) == 1) rand_req(we0, addr0, wdata0);
        else req0 = 0;
      end else if (keep0) addr0 = addr0 + 19'd1;
      else req0 = 0;
    end else if (!req0 && auto_en && $urandom_range(0, 2) == 0) begin
      req0 = 1;
      rand_req(we0, addr0, wdata0);
    end
    if (ack1 && req1) begin
      if (auto_en) begin
        if ($urandom_range(0, 1) == 1) rand_req(we1, addr1, wdata1);
        else req1 = 0;
      end else if (keep1) addr1 = addr1 + 19'd1;
      else req1 = 0;
    end else if (!req1 && auto_en && $urandom_range(0, 2) == 0) begin
      req1 = 1;
      rand_req(we1, addr1, wdata1);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check_cycle();
      drive();
    end
  endtask

  initial begin
    reset = 1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #2;
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dout", sram_dout, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clock);
    reset = 0;

    // Port 1 read of a known location.
    dev_mem[32'h12345] = 8'hA5;
    ref_mem[32'h12345] = 8'hA5;
    clear_logs();
    req1 = 1; we1 = 0; addr1 = 19'h12345;
    run_cycles(W + 4);
    chk("t1_acks", ack_edges.size(), 1);
    if (ack_edges.size() > 0 && grant_edges.size() > 0) begin
      chk("t1_port", ack_ports[0], 1);
      chk("t1_lat", ack_edges[0] - grant_edges[0], W);
    end
    chk("t1_rdata", rdata, 8'hA5);
    chk("t1_oe_cycles", n_oel, W);

    // Port 0 write to the top address.
    clear_logs();
    req0 = 1; we0 = 1; addr0 = 19'h7FFFF; wdata0 = 8'h3C;
    run_cycles(W + 4);
    chk("t2_acks", ack_edges.size(), 1);
    chk("t2_we_cycles", n_wel, W);
    chk("t2_dq_cycles", n_dq, W + 1);
    chk("t2_mem", dev_rd(32'h7FFFF), 8'h3C);

    // Simultaneous single requests.
    clear_logs();
    req0 = 1; we0 = 0; addr0 = 19'h00100;
    req1 = 1; we1 = 0; addr1 = 19'h00200;
    run_cycles(2 * (W + 2) + 2);
    chk("t3_acks", ack_edges.size(), 2);
    if (ack_edges.size() == 2 && grant_ports.size() == 2) begin
      chk("t3_first", ack_ports[0], grant_ports[0]);
      chk("t3_second", ack_ports[1], grant_ports[1]);
      chk("t3_gap", ack_edges[1] - ack_edges[0], W + 2);
    end

    // Request held across ack: back-to-back reads of 0 and 1.
    clear_logs();
    keep0 = 1;
    req0 = 1; we0 = 0; addr0 = 19'h00000;
    run_cycles(2 * W + 4);
    keep0 = 0;
    req0 = 0;
    chk("t6_acks", ack_edges.size(), 2);
    if (ack_edges.size() == 2)
      chk("t6_gap", ack_edges[1] - ack_edges[0], W + 2);
    run_cycles(W + 2);

    // Reset during the second ACCESS cycle of a write.
    clear_logs();
    req0 = 1; we0 = 1; addr0 = 19'h0ABCD; wdata0 = 8'h77;
    run_cycles(2);
    chk("t5_we_low", sram_we_n, 0);
    reset = 1;
    #1;
    chk("t5_we_n", sram_we_n, 1);
    chk("t5_ce_n", sram_ce_n, 1);
    chk("t5_dq_oe", sram_dq_oe, 0);
    req0 = 0;
    ref_mem[32'h0ABCD] = 8'h77;
    @(posedge clock);
    #1;
    chk("t5_ack0", ack0, 0);
    @(negedge clock);
    reset = 0;
    act = 0;
    free_edge = 0;
    last1 = 1;
    exp_rdata = 8'h00;

    // Continuous contention straight after reset.
    clear_logs();
    keep0 = 1; keep1 = 1;
    req0 = 1; we0 = 0; addr0 = 19'h00010;
    req1 = 1; we1 = 0; addr1 = 19'h00020;
    run_cycles(8 * (W + 2) + 1);
    chk("t4_acks", ack_edges.size() >= 8, 1);
    if (ack_edges.size() >= 8) begin
      for (int i = 0; i < 8; i++)
        chk($sformatf("t4_port%0d", i), ack_ports[i], RR ? i % 2 : 0);
      for (int i = 1; i < 8; i++)
        chk($sformatf("t4_gap%0d", i), ack_edges[i] - ack_edges[i-1], W + 2);
    end
    keep0 = 0; keep1 = 0;

    // Random traffic.
    auto_en = 1;
    run_cycles(3000);
    auto_en = 0;
    run_cycles(3 * (W + 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
